// File: rtl/down_counter.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Counts a reload value down to zero on en ticks and pulses tc on expiry.
module down_counter #(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [n-1:0] load_val,
  input  logic         start,
  input  logic         en,
  input  logic         auto_reload,
  output logic [n-1:0] Q,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [n-1:0] ONE  = {{(n-1){1'b0}}, 1'b1};
  localparam logic [n-1:0] ZERO = '0;

  state_t       state;
  logic [n-1:0] reload_reg;
  logic         can_start;
  logic         expire;

  assign can_start = start && (reload_reg != ZERO);
  // Expiry is caught at Q=1 so the decrement never wraps.
  assign expire    = en && (Q == ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      Q          <= ZERO;
      reload_reg <= ZERO;
      tc         <= 1'b0;
    end else if (load) begin
      state      <= IDLE;
      Q          <= load_val;
      reload_reg <= load_val;
      tc         <= 1'b0;
    end else begin
      tc <= 1'b0;
      unique case (state)
        IDLE: begin
          if (can_start) begin
            Q     <= reload_reg;
            state <= RUN;
          end
        end
        RUN: begin
          if (expire) begin
            tc <= 1'b1;
            if (auto_reload) begin
              Q <= reload_reg;
            end else begin
              Q     <= ZERO;
              state <= DONE;
            end
          end else if (en) begin
            Q <= Q - ONE;
          end
        end
        DONE: begin
          if (can_start) begin
            Q     <= reload_reg;
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          Q     <= ZERO;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: directed vector table, hand sequences,
// and random traffic against a tick-count reference model.
module tb_down_counter;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [N-1:0] load_val;
  logic         start;
  logic         en;
  logic         auto_reload;
  logic [N-1:0] q;
  logic         tc;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  down_counter #(.n(N)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(load_val),
    .start(start),
    .en(en),
    .auto_reload(auto_reload),
    .Q(q),
    .tc(tc),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Reference: count en ticks since start; period L.
  int L;
  int k;
  int idle_q;
  bit running;
  bit finished;
  bit m_tc;

  function automatic int m_q();
    if (running) return L - (k % L);
    if (finished) return 0;
    return idle_q;
  endfunction

  task automatic model(input bit r, l, input int lv,
                       input bit s, e, a);
    m_tc = 1'b0;
    if (r) begin
      L = 0; idle_q = 0; running = 0; finished = 0;
    end else if (l) begin
      L = lv; idle_q = lv; running = 0; finished = 0;
    end else if (!running) begin
      if (s && L != 0) begin
        running = 1; finished = 0; k = 0;
      end
    end else if (e) begin
      k++;
      if (k % L == 0) begin
        m_tc = 1'b1;
        if (!a) begin
          running = 0; finished = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit r, l, input int lv,
                      input bit s, e, a);
    reset = r; load = l; load_val = lv[N-1:0];
    start = s; en = e; auto_reload = a;
    model(r, l, lv, s, e, a);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".Q"}, int'(q), m_q());
    chk({tag, ".tc"}, int'(tc), int'(m_tc));
    chk({tag, ".busy"}, int'(busy), int'(running));
    chk({tag, ".done"}, int'(done), int'(finished));
  endtask

  typedef struct {
    bit r, l;
    int lv;
    bit s, e, a;
    int q;
    bit tc, busy, done;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(bit r, l, int lv, bit s, e, a,
                            int eq, bit et, eb, ed);
    vec_t t;
    t.r = r; t.l = l; t.lv = lv; t.s = s; t.e = e; t.a = a;
    t.q = eq; t.tc = et; t.busy = eb; t.done = ed;
    vecs.push_back(t);
  endfunction

  initial begin
    // One-shot L=5
    v(1,0,0,0,0,0, 0,0,0,0);
    v(1,0,0,0,0,0, 0,0,0,0);
    v(0,0,0,1,0,0, 0,0,0,0);
    v(0,1,5,0,0,0, 5,0,0,0);
    v(0,0,0,1,1,0, 5,0,1,0);
    v(0,0,0,0,1,0, 4,0,1,0);
    v(0,0,0,0,1,0, 3,0,1,0);
    v(0,0,0,0,1,0, 2,0,1,0);
    v(0,0,0,0,1,0, 1,0,1,0);
    v(0,0,0,0,1,0, 0,1,0,1);
    v(0,0,0,0,1,0, 0,0,0,1);
    v(0,0,0,0,1,0, 0,0,0,1);
    // Restart from DONE, then load+start priority at Q=2
    v(0,0,0,1,0,0, 5,0,1,0);
    v(0,0,0,0,1,0, 4,0,1,0);
    v(0,0,0,0,1,0, 3,0,1,0);
    v(0,0,0,0,1,0, 2,0,1,0);
    v(0,1,7,1,1,0, 7,0,0,0);
    v(0,0,0,0,1,0, 7,0,0,0);
    v(0,0,0,1,0,0, 7,0,1,0);
    v(0,0,0,0,1,0, 6,0,1,0);
    v(0,0,0,1,1,0, 5,0,1,0);
    v(0,0,0,1,0,0, 5,0,1,0);
    // Reset mid-run; then start with no load stays idle
    v(1,0,0,0,1,0, 0,0,0,0);
    v(1,0,0,0,1,0, 0,0,0,0);
    v(0,0,0,1,1,0, 0,0,0,0);
    // Auto-reload L=3
    v(0,1,3,0,0,1, 3,0,0,0);
    v(0,0,0,1,0,1, 3,0,1,0);
    v(0,0,0,0,1,1, 2,0,1,0);
    v(0,0,0,0,1,1, 1,0,1,0);
    v(0,0,0,0,1,1, 3,1,1,0);
    v(0,0,0,0,1,1, 2,0,1,0);
    v(0,0,0,0,1,1, 1,0,1,0);
    v(0,0,0,0,1,1, 3,1,1,0);
    v(0,0,0,0,1,0, 2,0,1,0);
    v(0,0,0,0,1,0, 1,0,1,0);
    v(0,0,0,0,1,0, 0,1,0,1);
    // Auto-reload L=1
    v(0,1,1,0,0,1, 1,0,0,0);
    v(0,0,0,1,1,1, 1,0,1,0);
    v(0,0,0,0,1,1, 1,1,1,0);
    v(0,0,0,0,1,1, 1,1,1,0);
    v(0,0,0,0,0,1, 1,0,1,0);
    v(0,0,0,0,1,1, 1,1,1,0);
    // Load 0 never runs
    v(0,1,0,0,0,0, 0,0,0,0);
    v(0,0,0,1,1,0, 0,0,0,0);
    v(0,0,0,1,1,1, 0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t t;
      string nm;
      t = vecs[i];
      step(t.r, t.l, t.lv, t.s, t.e, t.a);
      nm = $sformatf("vec%0d", i);
      chk({nm, ".Q"}, int'(q), t.q);
      chk({nm, ".tc"}, int'(tc), int'(t.tc));
      chk({nm, ".busy"}, int'(busy), int'(t.busy));
      chk({nm, ".done"}, int'(done), int'(t.done));
    end

    // Gated en: tc after 4th pulse, 12 cycles after start
    begin
      int pulses;
      pulses = 0;
      step(0,1,4,0,0,0);
      step(0,0,0,1,0,0);
      for (int c = 1; c <= 13; c++) begin
        bit e;
        e = (c % 3 == 0) && c <= 12;
        step(0,0,0,0,e,0);
        if (e) pulses++;
        chk($sformatf("gate%0d.Q", c), int'(q),
            pulses >= 4 ? 0 : 4 - pulses);
        chk($sformatf("gate%0d.tc", c), int'(tc),
            int'(c == 12));
      end
    end

    // Full-scale period: load 1023
    begin
      int cyc;
      bit seen;
      seen = 0;
      cyc = 0;
      step(0,1,1023,0,0,0);
      chk("max.load", int'(q), 1023);
      step(0,0,0,1,0,0);
      while (!seen && cyc < 1100) begin
        step(0,0,0,0,1,0);
        cyc++;
        if (tc) seen = 1;
      end
      chk("max.seen", int'(seen), 1);
      chk("max.period", cyc, 1023);
      chk("max.done", int'(done), 1);
      chk("max.Q", int'(q), 0);
    end

    // Random traffic against the reference model
    step(1,0,0,0,0,0);
    chk_model("rst");
    begin
      bit a;
      a = 0;
      for (int i = 0; i < 4000; i++) begin
        bit r, l, s, e;
        int lv;
        r = ($urandom_range(0, 99) == 0);
        l = ($urandom_range(0, 24) == 0);
        s = ($urandom_range(0, 3) == 0);
        e = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 29) == 0) a = ~a;
        lv = ($urandom_range(0, 7) == 0) ?
             int'($urandom_range(0, 1023)) :
             int'($urandom_range(0, 9));
        step(r, l, lv, s, e, a);
        chk_model($sformatf("rnd%0d", i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/down_counter.md
# down_counter

Programmable, loadable down-counter/timer for the VGA timing path. It complements the free-running pixel/line up-counters by counting a loaded value down to zero on qualified ticks, such as pixel-clock enables or end-of-line strobes. It signals expiry with a one-cycle terminal-count pulse and supports one-shot or auto-reload operation. Sync/porch interval timers and frame-countdown logic instantiate it.

## Interface
- n, 10, counter width in bits; maximum load value is 2^n − 1
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  when high, capture load_val into reload register and Q
- load_val  in  n  value to load
- start  in  1  begin counting from the reload register value
- en  in  1  count qualifier; decrement happens only on cycles with en=1
- auto_reload  in  1  1 = periodic mode, 0 = one-shot mode
- Q  out  n  current count, registered
- tc  out  1  terminal-count pulse, one cycle wide, registered
- busy  out  1  high while in RUN
- done  out  1  high while in DONE (one-shot mode only)

## Operation
- Internal state:
  - reload_reg[n−1:0]
  - Q_reg[n−1:0]
  - FSM with states IDLE, RUN, DONE
  - tc register
- Reset (reset=1 at a rising edge): state=IDLE, Q=0, reload_reg=0, tc=0, busy=0, done=0.
- Priority in every state: reset > load > start > en.
- load=1:
  - reload_reg ← load_val and Q ← load_val.
  - State → IDLE, tc ← 0. This aborts any RUN or DONE.
  - start in the same cycle is ignored.
- IDLE:
  - start=1 with reload_reg≠0: Q ← reload_reg, state → RUN.
  - start=1 with reload_reg=0: ignored; stay in IDLE, no tc.
  - en is ignored.
- RUN, en=0: Q holds, tc ← 0.
- RUN, en=1, Q>1: Q ← Q−1, tc ← 0.
- RUN, en=1, Q=1 (expiry): tc ← 1, then:
  - auto_reload=1: Q ← reload_reg, stay in RUN.
  - auto_reload=0: Q ← 0, state → DONE.
- auto_reload is sampled only on the expiry cycle, so changing it mid-count affects only the next expiry.
- start while in RUN is ignored. A count is never restarted without load.
- DONE:
  - Q=0, done=1; en is ignored.
  - start=1 with reload_reg≠0: Q ← reload_reg, state → RUN.
  - start=1 with reload_reg=0: ignored; stay in DONE.
- tc is high for exactly one cycle per expiry and is cleared on every other cycle.
- busy = (state==RUN) and done = (state==DONE), both decoded from the state register, so glitch-free.
- Arithmetic:
  - Decrement is modulo-free; Q never underflows because expiry is detected at Q=1.
  - A load value of 2^n−1 gives a period of 2^n−1 en ticks.

## Timing
- Latency from load: load sampled at edge k → Q=load_val visible after edge k.
- Latency from start: start sampled at edge k → busy=1 and Q=reload_reg after edge k. The first decrement can occur at edge k+1 if en=1.
- Period with en held high, load value L≥1:
  - tc asserts after edge k+L, L cycles after start.
  - In auto-reload mode, tc repeats every L cycles.
- Period with en gated: tc follows the L-th sampled en=1 after start.
- When tc is high, Q shows either the reload value (auto-reload) or 0 (one-shot). In one-shot mode busy falls and done rises in that same cycle.
- L=1 in auto-reload mode: tc is high on every cycle with en=1, and Q stays at 1.
- Reset in the middle of RUN: all outputs return to reset values after that edge. A pending tc is lost.
- No combinational path from any input to any output.

## Test plan
- Reset: assert reset for 2 cycles mid-RUN → Q=0, tc=0, busy=0, done=0. A following start with no load stays in IDLE.
- One-shot, n=10: load 5, start, en=1 constantly → Q counts 5,4,3,2,1,0. tc pulses once, exactly 5 cycles after start. busy falls and done rises in the tc cycle. Further en produces no tc.
- Auto-reload: load 3, auto_reload=1, start, en=1 for 10 cycles → tc in cycles 3, 6, 9 after start. Q sequence 3,2,1,3,2,1,…; busy stays 1.
- Gated en: load 4, start, en high every third cycle → tc after the 4th en pulse (cycle 12). Q holds between en pulses.
- Priorities: during RUN with Q=2, assert load(7) and start together → Q=7, IDLE, no tc. Then start alone → RUN. start again while in RUN → ignored, count continues.
- Boundaries:
  - load 1023, start, en=1 → tc after 1023 cycles.
  - load 0, start → stays in IDLE, never tc.
  - auto_reload=1, L=1 → tc every en cycle.
